// File: rtl/input_controller_xy_pkg.sv
`default_nettype none
// ============================================================================
// Module  : input_controller_xy_pkg
// Brief   : Flit field positions and direction encodings for the XY input stage.
// Revision: 1.0
// ============================================================================
package input_controller_xy_pkg;

    localparam int FLIT_W = 64;

    localparam int VC_BIT = 63;
    localparam int DX_BIT = 62;
    localparam int DY_BIT = 61;
    localparam int HX_HI  = 55;
    localparam int HX_LO  = 52;
    localparam int HY_HI  = 51;
    localparam int HY_LO  = 48;

    typedef logic [2:0] dir_t;

    localparam dir_t DIR_N = 3'd0;
    localparam dir_t DIR_E = 3'd1;
    localparam dir_t DIR_S = 3'd2;
    localparam dir_t DIR_W = 3'd3;
    localparam dir_t DIR_L = 3'd4;

endpackage
`default_nettype wire

// File: rtl/input_controller_xy_if.sv
`default_nettype none
// ============================================================================
// Module  : input_controller_xy_if
// Brief   : Link-side and output-controller-side handshake bundle.
// Revision: 1.0
// ============================================================================
interface input_controller_xy_if;
    import input_controller_xy_pkg::*;

    logic              in_si;
    logic [FLIT_W-1:0] in_di;
    logic              in_ri;

    logic              n_so, e_so, s_so, w_so, l_so;
    logic [FLIT_W-1:0] n_do, e_do, s_do, w_do, l_do;
    logic              n_ro, e_ro, s_ro, w_ro, l_ro;

    // Environment view: upstream link plus the five downstream arbiters.
    modport master (
        output in_si, in_di,
        input  in_ri,
        input  n_so, e_so, s_so, w_so, l_so,
        input  n_do, e_do, s_do, w_do, l_do,
        output n_ro, e_ro, s_ro, w_ro, l_ro
    );

    modport slave (
        input  in_si, in_di,
        output in_ri,
        output n_so, e_so, s_so, w_so, l_so,
        output n_do, e_do, s_do, w_do, l_do,
        input  n_ro, e_ro, s_ro, w_ro, l_ro
    );

endinterface
`default_nettype wire

// File: rtl/input_controller_xy_vc_slot.sv
`default_nettype none
// ============================================================================
// Module  : input_controller_xy_vc_slot
// Brief   : One-flit virtual-channel buffer: full flag, flit and route.
// Revision: 1.0
// ============================================================================
module input_controller_xy_vc_slot
    import input_controller_xy_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_wr,
    input  wire logic [FLIT_W-1:0] i_flit,
    input  wire dir_t              i_route,
    input  wire logic              i_pop,
    output logic                   o_full,
    output logic [FLIT_W-1:0]      o_flit,
    output dir_t                   o_route
);

    logic              r_full;
    logic [FLIT_W-1:0] r_flit;
    dir_t              r_route;

    // Writes only land on an empty slot and pops only on a full one, so the
    // two strobes are never active together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full  <= 1'b0;
            r_flit  <= '0;
            r_route <= '0;
        end else if (i_wr) begin
            r_full  <= 1'b1;
            r_flit  <= i_flit;
            r_route <= i_route;
        end else if (i_pop) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_flit  = r_flit;
    assign o_route = r_route;

endmodule
`default_nettype wire

// File: rtl/input_controller_xy.sv
`default_nettype none
// ============================================================================
// Module  : input_controller_xy
// Brief   : Router input port: two polarity-timesliced VC slots, XY route
//           computation and a five-way demux toward the output arbiters.
// Revision: 1.0
// ============================================================================
module input_controller_xy
    import input_controller_xy_pkg::*;
#(
    parameter dir_t IN_DIR = DIR_N,
    parameter int   HOP_W  = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            polarity,
    input_controller_xy_if.slave io,
    output logic                 route_err
);

    localparam logic [HOP_W-1:0] c_HOP_ONE = {{(HOP_W-1){1'b0}}, 1'b1};

    logic [HOP_W-1:0]  w_hx;
    logic [HOP_W-1:0]  w_hy;
    logic [FLIT_W-1:0] w_wr_flit;
    dir_t              w_calc_route;
    dir_t              w_wr_route;
    logic              w_uturn;
    logic              w_wr_en;
    logic              w_pop_en;
    logic [1:0]        w_wr;
    logic [1:0]        w_pop;
    logic [1:0]        w_full;
    logic [FLIT_W-1:0] w_slot_flit [2];
    dir_t              w_slot_route [2];
    logic              w_act_full;
    logic [FLIT_W-1:0] w_act_flit;
    dir_t              w_act_route;
    logic              w_act_ro;
    logic              r_route_err;

    assign w_hx = io.in_di[HX_HI:HX_LO];
    assign w_hy = io.in_di[HY_HI:HY_LO];

    // X is exhausted before Y; a hop count is decremented only when nonzero.
    always_comb begin
        w_wr_flit    = io.in_di;
        w_calc_route = DIR_L;
        if (w_hx != '0) begin
            w_calc_route             = io.in_di[DX_BIT] ? DIR_W : DIR_E;
            w_wr_flit[HX_HI:HX_LO]   = w_hx - c_HOP_ONE;
        end else if (w_hy != '0) begin
            w_calc_route             = io.in_di[DY_BIT] ? DIR_S : DIR_N;
            w_wr_flit[HY_HI:HY_LO]   = w_hy - c_HOP_ONE;
        end
    end

    assign w_uturn    = (IN_DIR != DIR_L) && (w_calc_route == IN_DIR);
    assign w_wr_route = w_uturn ? DIR_L : w_calc_route;

    // The link fills the VC that is not being forwarded this cycle.
    assign io.in_ri = reset & ~w_full[~polarity];
    assign w_wr_en  = io.in_si & io.in_ri & (io.in_di[VC_BIT] != polarity);

    for (genvar v = 0; v < 2; v++) begin : g_vc
        assign w_wr[v]  = w_wr_en  & (io.in_di[VC_BIT] == 1'(v));
        assign w_pop[v] = w_pop_en & (polarity == 1'(v));

        input_controller_xy_vc_slot u_slot (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (w_wr[v]),
            .i_flit  (w_wr_flit),
            .i_route (w_wr_route),
            .i_pop   (w_pop[v]),
            .o_full  (w_full[v]),
            .o_flit  (w_slot_flit[v]),
            .o_route (w_slot_route[v])
        );
    end

    assign w_act_full  = w_full[polarity];
    assign w_act_flit  = w_slot_flit[polarity];
    assign w_act_route = w_slot_route[polarity];

    always_comb begin
        io.n_so  = 1'b0;
        io.e_so  = 1'b0;
        io.s_so  = 1'b0;
        io.w_so  = 1'b0;
        io.l_so  = 1'b0;
        io.n_do  = '0;
        io.e_do  = '0;
        io.s_do  = '0;
        io.w_do  = '0;
        io.l_do  = '0;
        w_act_ro = 1'b0;
        if (w_act_full) begin
            case (w_act_route)
                DIR_N: begin
                    io.n_so  = 1'b1;
                    io.n_do  = w_act_flit;
                    w_act_ro = io.n_ro;
                end
                DIR_E: begin
                    io.e_so  = 1'b1;
                    io.e_do  = w_act_flit;
                    w_act_ro = io.e_ro;
                end
                DIR_S: begin
                    io.s_so  = 1'b1;
                    io.s_do  = w_act_flit;
                    w_act_ro = io.s_ro;
                end
                DIR_W: begin
                    io.w_so  = 1'b1;
                    io.w_do  = w_act_flit;
                    w_act_ro = io.w_ro;
                end
                DIR_L: begin
                    io.l_so  = 1'b1;
                    io.l_do  = w_act_flit;
                    w_act_ro = io.l_ro;
                end
                default: begin
                    w_act_ro = 1'b0;
                end
            endcase
        end
    end

    assign w_pop_en = w_act_full & w_act_ro;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_route_err <= 1'b0;
        end else begin
            r_route_err <= w_wr_en & w_uturn;
        end
    end

    assign route_err = r_route_err;

endmodule
`default_nettype wire

// File: tb/tb_input_controller_xy.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_controller_xy
// Brief   : Scoreboard bench for input_controller_xy with a field-level model.
// Revision: 1.0
// ============================================================================
module tb_input_controller_xy;
    import input_controller_xy_pkg::*;

    localparam dir_t c_IN_DIR = DIR_E;

    typedef struct packed {
        logic [2:0]  dest;
        logic [63:0] flit;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic polarity;
    logic route_err;

    input_controller_xy_if io();

    input_controller_xy #(
        .IN_DIR (c_IN_DIR),
        .HOP_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .io        (io),
        .route_err (route_err)
    );

    always #5 clk = ~clk;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    logic exp_ri   = 1'b0;
    logic exp_err  = 1'b0;
    logic pend_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] mkflit(input logic vc, input logic dx, input logic dy,
                                           input logic [3:0] hx, input logic [3:0] hy);
        logic [63:0] r;
        logic [4:0]  rsv;
        r   = {$urandom, $urandom};
        rsv = r[60:56];
        return {vc, dx, dy, rsv, hx, hy, r[47:0]};
    endfunction

    function automatic logic [63:0] rnd_flit();
        return mkflit(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                      4'($urandom_range(3)), 4'($urandom_range(3)));
    endfunction

    // Dimension-order routing straight from the flit fields.
    function automatic void ref_route(input logic [63:0] f, output logic [2:0] dest,
                                      output logic [63:0] nf, output logic err);
        int hx;
        int hy;
        hx  = int'(f[55:52]);
        hy  = int'(f[51:48]);
        nf  = f;
        err = 1'b0;
        if (hx > 0) begin
            dest        = f[62] ? 3'd3 : 3'd1;
            nf[55:52]   = 4'(hx - 1);
        end else if (hy > 0) begin
            dest        = f[61] ? 3'd2 : 3'd0;
            nf[51:48]   = 4'(hy - 1);
        end else begin
            dest        = 3'd4;
        end
        if (dest == c_IN_DIR && c_IN_DIR != 3'd4) begin
            dest = 3'd4;
            err  = 1'b1;
        end
    endfunction

    task automatic set_ro(input logic [4:0] r);
        io.n_ro = r[0];
        io.e_ro = r[1];
        io.s_ro = r[2];
        io.w_ro = r[3];
        io.l_ro = r[4];
    endtask

    // vcmode: 0 keep flit's vc, 1 target the writable VC, 2 target the busy timeslot.
    task automatic cycle(input logic rstv, input logic si, input logic [63:0] di,
                         input int vcmode, input logic [4:0] ro);
        logic [63:0] f;
        logic [63:0] nf;
        logic [2:0]  d;
        logic        e;
        bit          occ;
        @(posedge clk);
        #1;
        polarity = ~polarity;
        reset    = rstv;
        f        = di;
        if (vcmode == 1) f[63] = ~polarity;
        else if (vcmode == 2) f[63] = polarity;
        io.in_si = si;
        io.in_di = f;
        set_ro(ro);
        exp_err  = pend_err;
        pend_err = 1'b0;
        if (!reset) begin
            q0.delete();
            q1.delete();
            exp_err = 1'b0;
            exp_ri  = 1'b0;
        end else begin
            occ    = polarity ? (q0.size() != 0) : (q1.size() != 0);
            exp_ri = !occ;
            if (si && exp_ri && f[63] != polarity) begin
                ref_route(f, d, nf, e);
                if (f[63]) q1.push_back('{d, nf});
                else       q0.push_back('{d, nf});
                pend_err = e;
            end
        end
    endtask

    logic [4:0]  m_so;
    logic [4:0]  m_ro;
    logic [63:0] m_do [5];
    logic [63:0] m_oth;
    exp_t        m_e;
    bit          m_pres;

    always @(negedge clk) begin
        m_so    = {io.l_so, io.w_so, io.s_so, io.e_so, io.n_so};
        m_ro    = {io.l_ro, io.w_ro, io.s_ro, io.e_ro, io.n_ro};
        m_do[0] = io.n_do;
        m_do[1] = io.e_do;
        m_do[2] = io.s_do;
        m_do[3] = io.w_do;
        m_do[4] = io.l_do;
        m_pres  = polarity ? (q1.size() != 0) : (q0.size() != 0);
        if (m_pres) begin
            m_e = polarity ? q1[0] : q0[0];
            chk("so_onehot", 64'(m_so), 64'(5'b00001 << m_e.dest));
            chk("do_route", m_do[m_e.dest], m_e.flit);
            m_oth = '0;
            for (int d = 0; d < 5; d++) begin
                if (d != int'(m_e.dest)) m_oth = m_oth | m_do[d];
            end
            chk("do_others", m_oth, 64'h0);
            if (m_ro[m_e.dest]) begin
                if (polarity) void'(q1.pop_front());
                else          void'(q0.pop_front());
            end
        end else begin
            chk("so_idle", 64'(m_so), 64'h0);
        end
        chk("in_ri", 64'(io.in_ri), 64'(exp_ri));
        chk("route_err", 64'(route_err), 64'(exp_err));
    end

    initial begin
        reset    = 1'b0;
        polarity = 1'b0;
        io.in_si = 1'b0;
        io.in_di = '0;
        set_ro(5'h00);

        repeat (3) cycle(1'b0, 1'b0, 64'h0, 0, 5'h00);
        cycle(1'b1, 1'b0, 64'h0, 0, 5'h1F);

        // West hop, then local delivery.
        cycle(1'b1, 1'b1, mkflit(1'b0, 1'b1, 1'b0, 4'd2, 4'd1), 1, 5'h1F);
        cycle(1'b1, 1'b1, mkflit(1'b0, 1'b0, 1'b0, 4'd0, 4'd0), 1, 5'h1F);
        cycle(1'b1, 1'b0, 64'h0, 0, 5'h1F);

        // North with the north arbiter stalled for four cycles.
        cycle(1'b1, 1'b1, mkflit(1'b0, 1'b0, 1'b0, 4'd0, 4'd2), 1, 5'h1E);
        repeat (4) cycle(1'b1, 1'b0, 64'h0, 0, 5'h1E);
        repeat (2) cycle(1'b1, 1'b0, 64'h0, 0, 5'h1F);

        // U-turn toward this port's own direction, then a mistimed flit.
        cycle(1'b1, 1'b1, mkflit(1'b0, 1'b0, 1'b0, 4'd1, 4'd0), 1, 5'h1F);
        repeat (2) cycle(1'b1, 1'b0, 64'h0, 0, 5'h1F);
        cycle(1'b1, 1'b1, rnd_flit(), 2, 5'h1F);
        cycle(1'b1, 1'b0, 64'h0, 0, 5'h1F);

        // Back-to-back alternating VCs with every arbiter ready.
        repeat (24) cycle(1'b1, 1'b1, rnd_flit(), 1, 5'h1F);

        // Random traffic and random backpressure.
        repeat (400) cycle(1'b1, 1'($urandom_range(3) != 0), rnd_flit(),
                           ($urandom_range(2) == 0) ? 0 : 1, 5'($urandom));

        // Reset while a VC is occupied and stalled.
        cycle(1'b1, 1'b1, mkflit(1'b0, 1'b0, 1'b1, 4'd0, 4'd1), 1, 5'h00);
        cycle(1'b1, 1'b0, 64'h0, 0, 5'h00);
        repeat (2) cycle(1'b0, 1'b1, rnd_flit(), 1, 5'h1F);
        cycle(1'b1, 1'b0, 64'h0, 0, 5'h1F);
        repeat (50) cycle(1'b1, 1'($urandom_range(1)), rnd_flit(), 0, 5'($urandom));
        repeat (6) cycle(1'b1, 1'b0, 64'h0, 0, 5'h1F);

        @(negedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
